// File: rtl/popcount_seq_ctrl.sv
// Multi-cycle ones counter: accepts a wide operand, sums CHUNK bits per cycle through a
// narrow popcount, and returns the total over a valid/ready handshake.
module popcount_seq_ctrl #(
  parameter int unsigned W     = 255,
  parameter int unsigned CHUNK = 16,
  parameter int unsigned CW    = $clog2(W + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [W-1:0]  in_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [CW-1:0] out_count,
  output logic          busy
);

  localparam int unsigned NCHUNK = (W + CHUNK - 1) / CHUNK;
  localparam int unsigned PADW   = NCHUNK * CHUNK;
  localparam int unsigned IW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam int unsigned PW     = $clog2(CHUNK + 1);
  localparam logic [IW-1:0] LastIdx = IW'(NCHUNK - 1);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e          state_q;
  logic [IW-1:0]   idx_q;
  logic [CW-1:0]   acc_q;
  logic [PADW-1:0] opnd_q;
  logic            in_ready_q;
  logic            out_valid_q;
  logic            busy_q;

  logic [CHUNK-1:0] chunk;
  logic [PW-1:0]    chunk_cnt;

  // Operand is zero-extended on capture, so padding bits of the last chunk count as 0.
  always_comb begin
    chunk     = CHUNK'(opnd_q >> (32'(idx_q) * CHUNK));
    chunk_cnt = '0;
    for (int i = 0; i < int'(CHUNK); i++) begin
      chunk_cnt = chunk_cnt + PW'(chunk[i]);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      idx_q       <= '0;
      acc_q       <= '0;
      opnd_q      <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (in_valid && in_ready_q) begin
            opnd_q     <= PADW'(in_data);
            acc_q      <= '0;
            idx_q      <= '0;
            in_ready_q <= 1'b0;
            busy_q     <= 1'b1;
            state_q    <= StRun;
          end
        end
        StRun: begin
          acc_q <= acc_q + CW'(chunk_cnt);
          idx_q <= idx_q + 1'b1;
          if (idx_q == LastIdx) begin
            out_valid_q <= 1'b1;
            state_q     <= StDone;
          end
        end
        StDone: begin
          if (out_valid_q && out_ready) begin
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= StIdle;
          end
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_count = acc_q;
  assign busy      = busy_q;

endmodule
